// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction-fetch stage placed directly in front of the single-cycle
// controller/datapath. It holds the architectural PC and fetches one
// instruction per step over a req/ack memory handshake, which tolerates any
// number of wait states. It presents the latched instruction and its decoded
// Op/F3/F7 fields. Once the core reports exec_done, it computes the next PC
// from the controller's 2-bit PC select.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active low
//   pc_sel       in   next-PC select: 00/11 = PC+4, 01 = PC+imm, 10 = jalr
//   imm          in   sign-extended immediate from the datapath
//   jalr_target  in   rs1+imm from the ALU (bit 0 is cleared here)
//   exec_done    in   core finished the presented instruction this cycle
//   imem_req     out  fetch request, held until imem_ack
//   imem_addr    out  fetch address (always equal to pc)
//   imem_ack     in   memory returns imem_rdata this cycle
//   imem_rdata   in   instruction word, valid with imem_ack
//   instr        out  latched instruction
//   instr_valid  out  instr/pc may be executed
//   Op/F3/F7     out  instr[6:0] / instr[14:12] / instr[31:25]
//   pc           out  PC of the presented instruction
//   pc_plus4     out  pc+4, link value for jal/jalr
//   retired      out  completed-instruction count, wraps at 2^32
//   fault        out  sticky misaligned next-PC flag

module fetch_unit #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            exec_done,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [6:0]      Op,
  output logic [2:0]      F3,
  output logic [6:0]      F7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     retired,
  output logic            fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [31:0]     r_retired;
  logic            r_fault;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_nxt_aligned;

  // ------------------------------------------------------------------
  // Next-PC arithmetic (modulo 2^XLEN, no overflow detection)
  // ------------------------------------------------------------------
  assign w_pc_plus4 = r_pc + XLEN'(4);

  always_comb begin
    w_pc_nxt = w_pc_plus4;
    case (pc_sel)
      2'b01:   w_pc_nxt = r_pc + imm;
      // jalr clears bit 0 of the target, as RV32I requires
      2'b10:   w_pc_nxt = jalr_target & ~XLEN'(1);
      default: w_pc_nxt = w_pc_plus4;
    endcase
  end

  assign w_nxt_aligned = (w_pc_nxt[1:0] == 2'b00);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:  w_state_nxt = REQ;
      REQ:   if (imem_ack) w_state_nxt = VALID;
      VALID: if (exec_done) w_state_nxt = w_nxt_aligned ? REQ : FAULT;
      FAULT: w_state_nxt = FAULT;
      default: w_state_nxt = BOOT;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs decoded from the current state
  // ------------------------------------------------------------------
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      REQ:     imem_req    = 1'b1;
      VALID:   instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers. The reset branch comes first, so an ack that
  // arrives in the reset cycle is dropped.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_retired <= '0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
          end
        end
        VALID: begin
          if (exec_done) begin
            if (w_nxt_aligned) begin
              r_pc      <= w_pc_nxt;
              r_retired <= r_retired + 32'd1;
            end else begin
              r_fault   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Combinational outputs
  // ------------------------------------------------------------------
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign instr     = r_instr;
  assign Op        = r_instr[6:0];
  assign F3        = r_instr[14:12];
  assign F7        = r_instr[31:25];
  assign retired   = r_retired;
  assign fault     = r_fault;

endmodule
